key_calc_fsm: RTL and testbench

- Parametrised successor to the 3-bit two-key adder FSM.
- Captures two operands from a keypad-style input on discrete key-press edges, then executes a selectable ALU operation and holds the result with a carry/borrow flag.
- Supports chained calculation: a key press after a result makes that result operand A.
- Sits between the keypad front-end and the display/readout logic in the calculator datapath.

---
 rtl/key_calc_fsm.sv | 111 +++++++++++
 tb/tb_key_calc_fsm.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_calc_fsm.sv
// Two-operand keypad calculator: captures A and B on key-press edges, runs one
// ALU operation, holds the result with a carry/borrow flag and supports chaining.
module key_calc_fsm #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             KEY,
  input  logic [WIDTH-1:0] IN,
  input  logic [1:0]       OP,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] O,
  output logic             CY,
  output logic [1:0]       S,
  output logic             DONE,
  output logic [2:0]       LD
);

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_EXEC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic               key_q;
  logic               press;
  logic               ld_a, ld_b, ld_o;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_o;
  logic               alu_cy;

  assign press = KEY & ~key_q;
  assign S     = state;
  assign LD    = {ld_a, ld_b, ld_o};

  // key_q resets high so a key already held at reset release is not a press.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) key_q <= 1'b1;
    else     key_q <= KEY;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)      state <= S_A;
    else if (CLR) state <= S_A;
    else          state <= state_nxt;
  end

  // NOTE: a default assignment first keeps combinational blocks latch-free.
  always_comb begin
    state_nxt = S_A;
    case (state)
      S_A:     state_nxt = press ? S_B    : S_A;
      S_B:     state_nxt = press ? S_EXEC : S_B;
      S_EXEC:  state_nxt = S_DONE;
      S_DONE:  state_nxt = press ? S_EXEC : S_DONE;
      default: state_nxt = S_A;
    endcase
  end

  always_comb begin
    ld_a = ~CLR & press & ((state == S_A) | (state == S_DONE));
    ld_b = ~CLR & press & ((state == S_B) | (state == S_DONE));
    ld_o = ~CLR & (state == S_EXEC);
  end

  always_comb begin
    sum    = {1'b0, A} + {1'b0, B};
    prod   = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    alu_o  = '0;
    alu_cy = 1'b0;
    case (OP)
      2'b00: begin alu_o = sum[WIDTH-1:0];  alu_cy = sum[WIDTH];            end
      2'b01: begin alu_o = A - B;           alu_cy = (A < B);               end
      2'b10: begin alu_o = prod[WIDTH-1:0]; alu_cy = |prod[2*WIDTH-1:WIDTH]; end
      default: begin alu_o = A ^ B;         alu_cy = 1'b0;                  end
    endcase
  end

  // In S_DONE a press chains: the held result becomes operand A.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      A    <= '0;
      B    <= '0;
      O    <= '0;
      CY   <= 1'b0;
      DONE <= 1'b0;
    end else if (CLR) begin
      A    <= '0;
      B    <= '0;
      O    <= '0;
      CY   <= 1'b0;
      DONE <= 1'b0;
    end else begin
      if (ld_a) A <= (state == S_DONE) ? O : IN;
      if (ld_b) B <= IN;
      if (ld_o) begin
        O  <= alu_o;
        CY <= alu_cy;
      end
      DONE <= ld_o;
    end
  end

endmodule

// File: tb/tb_key_calc_fsm.sv
// Self-checking bench for key_calc_fsm: directed scenarios plus randomized
// operand/operation runs checked against a transaction-level arithmetic model.
module tb_key_calc_fsm;
  localparam int W = 8;
  localparam int M = 1 << W;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         CLR = 1'b0;
  logic         KEY = 1'b0;
  logic [W-1:0] IN  = '0;
  logic [1:0]   OP  = 2'b00;
  logic [W-1:0] A, B, O;
  logic         CY, DONE;
  logic [1:0]   S;
  logic [2:0]   LD;

  int checks = 0;
  int errors = 0;

  key_calc_fsm #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .KEY(KEY), .IN(IN), .OP(OP),
    .A(A), .B(B), .O(O), .CY(CY), .S(S), .DONE(DONE), .LD(LD)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Reference: result and carry from plain integer arithmetic.
  function automatic logic [W:0] ref_alu(input int a, input int b, input int op);
    int r;
    bit cy;
    case (op)
      0:       begin r = a + b;     cy = (r >= M); end
      1:       begin r = a - b + M; cy = (a < b);  end
      2:       begin r = a * b;     cy = (r >= M); end
      default: begin r = a ^ b;     cy = 1'b0;     end
    endcase
    r = r % M;
    return {cy, r[W-1:0]};
  endfunction

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic press(input logic [W-1:0] v);
    KEY = 1'b1;
    IN  = v;
    tick();
    KEY = 1'b0;
    tick();
  endtask

  task automatic do_clear();
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    KEY = 1'b1;
    @(negedge CLK);
    checks++;
    if ({A, B, O, CY, S, DONE, LD} !== '0) begin
      errors++;
      $display("FAIL reset_state: got A=%0d B=%0d O=%0d CY=%b S=%0d DONE=%b LD=%b required all zero",
               A, B, O, CY, S, DONE, LD);
    end
    RST = 1'b0;
    repeat (3) tick();
    checks++;
    if (A !== 0 || S !== 2'd0 || LD !== 3'b000) begin
      errors++;
      $display("FAIL held_key_at_reset: got A=%0d S=%0d LD=%b required A=0 S=0 LD=000", A, S, LD);
    end
    KEY = 1'b0;
    tick();
    KEY = 1'b1;
    IN  = 8'd33;
    #1;
    checks++;
    if (LD !== 3'b100) begin
      errors++;
      $display("FAIL repress_ld: got %b required 100", LD);
    end
    tick();
    KEY = 1'b0;
    tick();
    checks++;
    if (A !== 8'd33 || S !== 2'd1) begin
      errors++;
      $display("FAIL repress_load: got A=%0d S=%0d required A=33 S=1", A, S);
    end
    do_clear();
  endtask

  task automatic test_basic_and_chain();
    OP  = 2'b00;
    KEY = 1'b1;
    IN  = 8'd2;
    #1;
    checks++;
    if (LD !== 3'b100) begin errors++; $display("FAIL basic_ld_a: got %b required 100", LD); end
    tick();
    KEY = 1'b0;
    tick();
    KEY = 1'b1;
    IN  = 8'd4;
    #1;
    checks++;
    if (LD !== 3'b010) begin errors++; $display("FAIL basic_ld_b: got %b required 010", LD); end
    tick();
    KEY = 1'b0;
    #1;
    checks++;
    if (LD !== 3'b001 || S !== 2'd2 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL basic_exec: got LD=%b S=%0d DONE=%b required LD=001 S=2 DONE=0", LD, S, DONE);
    end
    tick();
    checks++;
    if (O !== 8'd6 || CY !== 1'b0 || DONE !== 1'b1 || S !== 2'd3) begin
      errors++;
      $display("FAIL basic_result: got O=%0d CY=%b DONE=%b S=%0d required O=6 CY=0 DONE=1 S=3",
               O, CY, DONE, S);
    end
    tick();
    checks++;
    if (DONE !== 1'b0 || O !== 8'd6) begin
      errors++;
      $display("FAIL done_pulse: got DONE=%b O=%0d required DONE=0 O=6", DONE, O);
    end
    KEY = 1'b1;
    IN  = 8'd10;
    #1;
    checks++;
    if (LD !== 3'b110) begin errors++; $display("FAIL chain_ld: got %b required 110", LD); end
    tick();
    KEY = 1'b0;
    checks++;
    if (A !== 8'd6 || B !== 8'd10 || S !== 2'd2) begin
      errors++;
      $display("FAIL chain_operands: got A=%0d B=%0d S=%0d required A=6 B=10 S=2", A, B, S);
    end
    tick();
    checks++;
    if (O !== 8'd16 || DONE !== 1'b1) begin
      errors++;
      $display("FAIL chain_result: got O=%0d DONE=%b required O=16 DONE=1", O, DONE);
    end
    do_clear();
  endtask

  task automatic test_ops();
    int va [4] = '{200, 3, 16, 'h0F};
    int vb [4] = '{100, 5, 17, 'hFF};
    int vo [4] = '{44, 254, 16, 'hF0};
    bit vc [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      do_clear();
      OP = 2'(i);
      press(8'(va[i]));
      press(8'(vb[i]));
      checks++;
      if (O !== 8'(vo[i]) || CY !== vc[i] || DONE !== 1'b1) begin
        errors++;
        $display("FAIL op%0d_vector: got O=%0d CY=%b DONE=%b required O=%0d CY=%b DONE=1",
                 i, O, CY, DONE, vo[i], vc[i]);
      end
    end
  endtask

  task automatic test_random();
    int a, b, c, op, op2;
    logic [W:0] exp1, exp2;
    for (int i = 0; i < 20; i++) begin
      do_clear();
      a  = $urandom_range(0, M - 1);
      b  = $urandom_range(0, M - 1);
      op = $urandom_range(0, 3);
      OP = 2'(op);
      press(8'(a));
      press(8'(b));
      exp1 = ref_alu(a, b, op);
      checks++;
      if ({CY, O} !== exp1 || DONE !== 1'b1 || S !== 2'd3) begin
        errors++;
        $display("FAIL rand_calc[%0d] a=%0d b=%0d op=%0d: got CY=%b O=%0d DONE=%b S=%0d required CY=%b O=%0d",
                 i, a, b, op, CY, O, DONE, S, exp1[W], exp1[W-1:0]);
      end
      c   = $urandom_range(0, M - 1);
      op2 = $urandom_range(0, 3);
      OP  = 2'(op2);
      press(8'(c));
      exp2 = ref_alu(int'(exp1[W-1:0]), c, op2);
      checks++;
      if (A !== exp1[W-1:0] || B !== 8'(c) || {CY, O} !== exp2) begin
        errors++;
        $display("FAIL rand_chain[%0d] c=%0d op=%0d: got A=%0d B=%0d CY=%b O=%0d required A=%0d B=%0d CY=%b O=%0d",
                 i, c, op2, A, B, CY, O, exp1[W-1:0], c, exp2[W], exp2[W-1:0]);
      end
    end
  endtask

  task automatic test_held_key();
    int loads = 0;
    do_clear();
    KEY = 1'b1;
    IN  = 8'd11;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (LD[2]) loads++;
      tick();
      IN = IN + 8'd1;
    end
    checks++;
    if (loads !== 1 || A !== 8'd11 || S !== 2'd1) begin
      errors++;
      $display("FAIL held_key: got loads=%0d A=%0d S=%0d required loads=1 A=11 S=1", loads, A, S);
    end
    KEY = 1'b0;
    tick();
  endtask

  task automatic test_clr_press();
    do_clear();
    press(8'd9);
    CLR = 1'b1;
    KEY = 1'b1;
    IN  = 8'd3;
    #1;
    checks++;
    if (LD !== 3'b000) begin errors++; $display("FAIL clr_ld: got %b required 000", LD); end
    tick();
    checks++;
    if ({A, B, O, CY, S, DONE} !== '0) begin
      errors++;
      $display("FAIL clr_state: got A=%0d B=%0d O=%0d CY=%b S=%0d DONE=%b required all zero",
               A, B, O, CY, S, DONE);
    end
    CLR = 1'b0;
    KEY = 1'b0;
    tick();
    press(8'd21);
    checks++;
    if (A !== 8'd21 || S !== 2'd1) begin
      errors++;
      $display("FAIL clr_then_press: got A=%0d S=%0d required A=21 S=1", A, S);
    end
  endtask

  task automatic test_exec_press();
    do_clear();
    OP = 2'b00;
    press(8'd5);
    KEY = 1'b1;
    IN  = 8'd7;
    tick();
    IN = 8'd99;
    #1;
    checks++;
    if (LD !== 3'b001 || S !== 2'd2) begin
      errors++;
      $display("FAIL exec_ld: got LD=%b S=%0d required LD=001 S=2", LD, S);
    end
    tick();
    checks++;
    if (B !== 8'd7 || O !== 8'd12 || S !== 2'd3) begin
      errors++;
      $display("FAIL exec_press_ignored: got B=%0d O=%0d S=%0d required B=7 O=12 S=3", B, O, S);
    end
    KEY = 1'b0;
    tick();
  endtask

  task automatic test_async_rst();
    do_clear();
    OP = 2'b10;
    press(8'd6);
    press(8'd7);
    tick();
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if ({A, B, O, CY, S, DONE} !== '0) begin
      errors++;
      $display("FAIL async_rst: got A=%0d B=%0d O=%0d CY=%b S=%0d DONE=%b required all zero",
               A, B, O, CY, S, DONE);
    end
    @(negedge CLK);
    RST = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_and_chain();
    test_ops();
    test_random();
    test_held_key();
    test_clr_press();
    test_exec_press();
    test_async_rst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
